apb4_master: RTL



---
 rtl/apb4_master_pkg.sv | 20 ++
 rtl/apb4_master_if.sv | 29 ++
 rtl/apb4_master.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/apb4_master_pkg.sv
// Shared types for the APB4 requester: FSM state encoding, PPROT width and
// the response record handed back to the command side.
package apb4_pkg;

    localparam int APB4_PROT_W     = 3;
    localparam int APB4_RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb4_mst_state_e;

    typedef struct packed {
        logic [APB4_RSP_DATA_W-1:0] rdata;
        logic                       err;
        logic                       timeout;
    } apb4_rsp_t;

endpackage

// File: rtl/apb4_master_if.sv
// APB4 bus bundle shared by requesters and completers.
interface apb4_intf #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    import apb4_pkg::*;

    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [APB4_PROT_W-1:0]  pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response pulse. A PREADY-low watchdog aborts the
// transfer so a hung completer cannot stall the command side.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a command; bus idle (PSEL=0)
//   ST_SETUP  | PSEL=1, PENABLE=0, captured command on the bus
//   ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or watchdog expiry
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_strb,
    input  logic [APB4_PROT_W-1:0]  i_req_prot,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,
    apb4_intf.master                m_apb
);

    // Counter is at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb4_mst_state_e         state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    cnt_at_limit;

    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic [APB4_PROT_W-1:0]  pprot_q;

    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;

    // Saturating wait-count increment and the "this low cycle is the last one" flag.
    always_comb begin
        cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        cnt_at_limit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    end

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        paddr_q   <= i_req_addr;
                        pwrite_q  <= i_req_is_wr;
                        pwdata_q  <= i_req_wdata;
                        pstrb_q   <= i_req_is_wr ? i_req_strb : '0;
                        pprot_q   <= i_req_prot;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_apb.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= m_apb.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : m_apb.prdata;
                    end else if (cnt_at_limit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= ST_IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = (state_q == ST_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_timeout_q;

    assign m_apb.paddr   = paddr_q;
    assign m_apb.psel    = psel_q;
    assign m_apb.penable = penable_q;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.pstrb   = pstrb_q;
    assign m_apb.pprot   = pprot_q;

endmodule
